// File: rtl/mont_mul_ctrl_if.sv
// mont_mul_ctrl_if: control/data bus between the Montgomery sequencer
// and the 514-bit carry-save mpadder.
interface mont_mul_ctrl_if #(
  parameter int W = 514
);
  logic         clear;
  logic [W-1:0] operand;
  logic         enableC;
  logic         shift;
  logic         subtract;
  logic [3:0]   chunk;
  logic         cZero;
  logic         sub_done;
  logic [W-1:0] result;

  modport master (
    output clear, operand, enableC, shift,
    output subtract, chunk,
    input  cZero, sub_done, result
  );

  modport slave (
    input  clear, operand, enableC, shift,
    input  subtract, chunk,
    output cZero, sub_done, result
  );
endinterface

// File: rtl/mont_mul_ctrl.sv
// mont_mul_ctrl: drives the mpadder through a*b*2^-NBITS mod m:
// bit loop, chunked resolve, then up to MAXSUB subtract passes.
module mont_mul_ctrl #(
  parameter int NBITS  = 512,
  parameter int NLIMB  = 5,
  parameter int MAXSUB = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [NBITS-1:0] in_a,
  input  logic [NBITS-1:0] in_b,
  input  logic [NBITS-1:0] in_m,
  mont_mul_ctrl_if.master  adder,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [NBITS-1:0] result
);

  localparam int W  = NBITS + 2;
  localparam int BW = $clog2(NBITS);
  localparam int PW = $clog2(MAXSUB + 1);

  localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);
  localparam logic [3:0]    LAST_CH  = 4'(NLIMB - 1);
  localparam logic [PW-1:0] MAX_PASS = PW'(MAXSUB);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_ADD_B,
    S_ADD_M,
    S_SHIFT,
    S_RESOLVE,
    S_CAPTURE,
    S_SUB,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [3:0]       chunk_q, chunk_d;
  logic [PW-1:0]    pass_q, pass_d;
  logic [NBITS-1:0] a_q, a_d;
  logic [NBITS-1:0] b_q, b_d;
  logic [NBITS-1:0] m_q, m_d;
  logic [NBITS-1:0] result_q, result_d;
  logic             error_q, error_d;

  logic         clr;
  logic [W-1:0] opnd;
  logic         en_c;
  logic         shf;
  logic         sub;
  logic [3:0]   chk;

  logic [W-1:0] b_ext;
  logic [W-1:0] m_ext;
  logic [W-1:0] negm;
  logic         unused_hi;

  assign b_ext = {2'b00, b_q};
  assign m_ext = {2'b00, m_q};
  // the adder injects the +1 on chunk 0, so only invert here
  assign negm  = ~m_ext;
  assign unused_hi = ^adder.result[W-1:NBITS];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      bit_q    <= '0;
      chunk_q  <= '0;
      pass_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      chunk_q  <= chunk_d;
      pass_q   <= pass_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    chunk_d  = chunk_q;
    pass_d   = pass_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    result_d = result_q;
    error_d  = error_q;
    clr      = 1'b0;
    opnd     = '0;
    en_c     = 1'b0;
    shf      = 1'b0;
    sub      = 1'b0;
    chk      = 4'd0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = in_a;
          b_d     = in_b;
          m_d     = in_m;
          bit_d   = '0;
          chunk_d = '0;
          pass_d  = '0;
          error_d = 1'b0;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        clr     = 1'b1;
        state_d = S_ADD_B;
      end
      S_ADD_B: begin
        opnd    = b_ext;
        en_c    = a_q[bit_q];
        state_d = S_ADD_M;
      end
      S_ADD_M: begin
        opnd    = m_ext;
        en_c    = adder.cZero;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        shf = 1'b1;
        if (bit_q == LAST_BIT) begin
          bit_d   = '0;
          chunk_d = '0;
          state_d = S_RESOLVE;
        end else begin
          bit_d   = bit_q + 1'b1;
          state_d = S_ADD_B;
        end
      end
      S_RESOLVE: begin
        chk = chunk_q;
        if (chunk_q == LAST_CH) begin
          chunk_d = '0;
          state_d = S_CAPTURE;
        end else begin
          chunk_d = chunk_q + 1'b1;
        end
      end
      S_CAPTURE: begin
        result_d = adder.result[NBITS-1:0];
        chunk_d  = '0;
        if (pass_q < MAX_PASS) begin
          state_d = S_SUB;
        end else begin
          error_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_SUB: begin
        sub  = 1'b1;
        opnd = negm;
        chk  = chunk_q;
        if (chunk_q == LAST_CH) begin
          chunk_d = '0;
          if (adder.sub_done) begin
            state_d = S_DONE;
          end else begin
            pass_d  = pass_q + 1'b1;
            state_d = S_CAPTURE;
          end
        end else begin
          chunk_d = chunk_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign adder.clear    = clr;
  assign adder.operand  = opnd;
  assign adder.enableC  = en_c;
  assign adder.shift    = shf;
  assign adder.subtract = sub;
  assign adder.chunk    = chk;

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign error  = error_q;
  assign result = result_q;

endmodule

// File: tb/tb_mont_mul_ctrl.sv
// tb_mont_mul_ctrl: behavioural mpadder stub, schedule monitor and
// arithmetic Montgomery reference for mont_mul_ctrl.
module tb_mont_mul_ctrl;

  localparam int N = 512;
  localparam int W = 514;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] in_a = '0;
  logic [N-1:0] in_b = '0;
  logic [N-1:0] in_m = '0;
  logic         busy, done, error;
  logic [N-1:0] result;

  mont_mul_ctrl_if #(.W(W)) bus ();

  mont_mul_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .in_a   (in_a),
    .in_b   (in_b),
    .in_m   (in_m),
    .adder  (bus),
    .busy   (busy),
    .done   (done),
    .error  (error),
    .result (result)
  );

  always #5 clk = ~clk;

  // adder stub: plain wide accumulator, resolve is implicit
  logic [W-1:0] acc = '0;
  logic         under;
  assign under = acc < ~bus.operand;
  assign bus.cZero = acc[0];
  assign bus.result = acc;
  assign bus.sub_done = bus.subtract && (bus.chunk == 4'd4) && under;

  always @(posedge clk) begin
    if (bus.clear) acc <= '0;
    else if (bus.enableC) acc <= acc + bus.operand;
    else if (bus.shift) acc <= acc >> 1;
    else if (bus.subtract && bus.chunk == 4'd4 && !under)
      acc <= acc + bus.operand + 1'b1;
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int mon_bad = 0;
  logic [N-1:0] mon_a, mon_b, mon_m;

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // fixed-schedule monitor up to the end of the first subtract pass
  always @(negedge clk) begin
    logic e_clr, e_en, e_sh, e_sub;
    logic [3:0] e_ch;
    logic [W-1:0] e_op;
    int k;
    if (mon_en && cyc >= 1 && cyc <= 1548) begin
      e_clr = 0; e_en = 0; e_sh = 0; e_sub = 0;
      e_ch = 4'd0; e_op = '0;
      if (cyc == 1) e_clr = 1;
      else if (cyc <= 1537) begin
        k = cyc - 2;
        case (k % 3)
          0: begin e_op = {2'b00, mon_b}; e_en = mon_a[k/3]; end
          1: begin e_op = {2'b00, mon_m}; e_en = bus.cZero; end
          default: e_sh = 1;
        endcase
      end else if (cyc <= 1542) e_ch = 4'(cyc - 1538);
      else if (cyc >= 1544) begin
        e_sub = 1;
        e_op = ~{2'b00, mon_m};
        e_ch = 4'(cyc - 1544);
      end
      if ({bus.clear, bus.enableC, bus.shift, bus.subtract,
           bus.chunk, bus.operand} !==
          {e_clr, e_en, e_sh, e_sub, e_ch, e_op})
        mon_bad++;
    end
  end

  function automatic void model(input logic [N-1:0] a, b, m,
                                output logic [N-1:0] r,
                                output int lat, output bit err);
    logic [3*N-1:0] ab, t;
    logic [N-1:0] inv, q;
    int j;
    ab = {1024'b0, a} * {1024'b0, b};
    inv = m;
    for (int i = 0; i < 10; i++) inv = inv * (512'd2 - m * inv);
    q = 512'd0 - ab[N-1:0] * inv;
    t = (ab + {1024'b0, q} * {1024'b0, m}) >> N;
    err = 0;
    lat = 0;
    j = 0;
    while (lat == 0) begin
      if (j == 2) begin
        err = 1;
        lat = 1556;
      end else if (t < {1024'b0, m}) begin
        lat = 1549 + 6 * j;
      end else begin
        t = t - {1024'b0, m};
        j++;
      end
    end
    r = t[N-1:0];
  endfunction

  task automatic run(input logic [N-1:0] a, b, m, output int lat);
    in_a = a; in_b = b; in_m = m;
    mon_a = a; mon_b = b; mon_m = m;
    mon_bad = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    mon_en = 1'b1;
    while (!done && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    lat = cyc;
    mon_en = 1'b0;
  endtask

  task automatic do_case(input string nm, input logic [N-1:0] a, b, m,
                         input logic [N-1:0] er, input int el,
                         input bit ee);
    int lat;
    run(a, b, m, lat);
    chk({nm, " latency"}, W'(lat), W'(el));
    chk({nm, " result"}, W'(result), W'(er));
    chk({nm, " error"}, W'(error), W'(ee));
    chk({nm, " schedule"}, W'(mon_bad), '0);
    @(posedge clk); #1;
    chk({nm, " idle"}, W'({busy, done}), '0);
  endtask

  function automatic logic [N-1:0] rnd512();
    logic [N-1:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  typedef struct {
    logic [N-1:0] a, b, m, r;
    int lat;
    bit err;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] a, b, m, er;
    int el, lat, dcount;
    bit ee;

    tbl[0] = '{a: 512'd1, b: 512'd1, m: 512'd3, r: 512'd1,
               lat: 1549, err: 0};
    tbl[1] = '{a: 512'd2, b: 512'd2, m: 512'd3, r: 512'd1,
               lat: 1549, err: 0};
    tbl[2] = '{a: 512'd0, b: 512'h1234_5678_9abc, m: 512'd5,
               r: 512'd0, lat: 1549, err: 0};
    tbl[3] = '{a: 512'd1, b: 512'd3, m: 512'd3, r: 512'd0,
               lat: 1555, err: 0};
    tbl[4] = '{a: '1, b: 512'd100, m: 512'd3, r: 512'd96,
               lat: 1556, err: 1};

    #1;
    chk("reset outs", W'({busy, done, error}), '0);
    chk("reset result", W'(result), '0);
    chk("reset bus", {bus.clear, bus.enableC, bus.shift,
        bus.subtract, bus.chunk}, '0);
    #20;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++)
      do_case($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].m,
              tbl[i].r, tbl[i].lat, tbl[i].err);

    for (int i = 0; i < 4; i++) begin
      m = rnd512();
      m[0] = 1'b1;
      a = rnd512();
      b = rnd512();
      if (i < 3) begin
        m[N-1] = 1'b1;
        if (a >= m) a = a - m;
        if (b >= m) b = b - m;
      end
      model(a, b, m, er, el, ee);
      do_case($sformatf("rnd%0d", i), a, b, m, er, el, ee);
    end

    in_a = 512'd2; in_b = 512'd2; in_m = 512'd3;
    mon_a = in_a; mon_b = in_b; mon_m = in_m;
    mon_bad = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    mon_en = 1'b1;
    dcount = 0;
    lat = 0;
    while (cyc < 1600) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 700) begin
        in_a = 512'd1; in_b = 512'd3; start = 1'b1;
      end else start = 1'b0;
      if (done) begin
        dcount++;
        if (lat == 0) lat = cyc;
      end
    end
    mon_en = 1'b0;
    chk("ignore done count", W'(dcount), W'(1));
    chk("ignore latency", W'(lat), W'(1549));
    chk("ignore result", W'(result), W'(1));
    chk("ignore schedule", W'(mon_bad), '0);

    in_a = rnd512(); in_b = rnd512(); in_m = rnd512() | 512'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 800) begin
      @(posedge clk); #1;
      cyc++;
    end
    #2;
    resetn = 1'b0;
    #1;
    chk("midreset outs", W'({busy, done, error}), '0);
    chk("midreset bus", {bus.clear, bus.enableC, bus.shift,
        bus.subtract, bus.chunk}, '0);
    chk("midreset operand", bus.operand, '0);
    chk("midreset result", W'(result), '0);
    #20;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    do_case("post-reset", tbl[1].a, tbl[1].b, tbl[1].m,
            tbl[1].r, tbl[1].lat, tbl[1].err);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
